// File: rtl/comp_pkg.sv
// Shared types and the golden two's-complement function for the complement-unit BIST.
// Operands up to 32 bits; callers truncate the result to their own width.
package comp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 4;

  function automatic logic [31:0] twos_comp(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/comp_ref.sv
// Combinational two's-complement reference: o = (~a + 1) mod 2^WIDTH.
// Latency 0 cycles; no flow control, purely combinational.
module comp_ref
  import comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] o
);

  assign o = WIDTH'(twos_comp(32'(a)));

endmodule

// File: rtl/comp_bist.sv
// Exhaustive BIST sweep of a WIDTH-bit complement unit; done 2^WIDTH*(DWELL+1) cycles after start.
// No backpressure: start is only honoured in IDLE/DONE and ignored while busy.
module comp_bist
  import comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  input  logic [WIDTH-1:0] dut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic             fail_seen,
  output logic [WIDTH-1:0] first_fail
);

  localparam logic [WIDTH-1:0] VEC_LAST   = '1;
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [WIDTH:0]   ERR_MAX    = {1'b1, {WIDTH{1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [7:0]       dwell_q, dwell_d;
  logic [WIDTH:0]   err_q, err_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic [WIDTH-1:0] exp_o;

  comp_ref #(.WIDTH(WIDTH)) u_ref (
    .a (vec_q),
    .o (exp_o)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dwell_d = dwell_q;
    err_d   = err_q;
    fail_d  = fail_q;
    first_d = first_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          dwell_d = '0;
          err_d   = '0;
          fail_d  = 1'b0;
          first_d = '0;
        end
      end
      S_DRIVE: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = S_CHECK;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      S_CHECK: begin
        if (dut_o != exp_o) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + (WIDTH+1)'(1);
          end
          if (!fail_q) begin
            fail_d  = 1'b1;
            first_d = vec_q;
          end
        end
        // Last vector stops the sweep rather than wrapping back to 0.
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + WIDTH'(1);
          dwell_d = '0;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      dwell_q <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      first_q <= first_d;
    end
  end

  assign dut_a      = vec_q;
  assign busy       = (state_q == S_DRIVE) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = (state_q == S_DONE) && (err_q == '0);
  assign err_count  = err_q;
  assign fail_seen  = fail_q;
  assign first_fail = first_q;

endmodule

// File: tb/tb_comp_bist.sv
// Directed bench for comp_bist: default instance (DWELL=2) with selectable unit models,
// plus a DWELL=1 instance for latency and hold-time checks.
module tb_comp_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2;
  logic [3:0] a1, o1, a2, o2;
  logic       busy1, done1, pass1, fs1;
  logic [4:0] err1;
  logic [3:0] ff1;
  logic       busy2, done2, pass2, fs2;
  logic [4:0] err2;
  logic [3:0] ff2;
  int         mode;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  // Unit model: 0 = correct two's complement, 1 = stuck at 0, 2 = one's complement.
  always_comb begin
    o1 = 4'd0;
    case (mode)
      0:       o1 = ~a1 + 4'd1;
      1:       o1 = 4'd0;
      default: o1 = ~a1;
    endcase
  end
  assign o2 = ~a2 + 4'd1;

  comp_bist #(.WIDTH(4), .DWELL(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_o(o1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_seen(fs1), .first_fail(ff1)
  );

  comp_bist #(.WIDTH(4), .DWELL(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dut_a(a2), .dut_o(o2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_seen(fs2), .first_fail(ff2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse (or hold) start on dut1, return cycles from accept edge to done.
  task automatic sweep1(input bit hold, output int cycles);
    start1 = 1'b1;
    tick();
    if (!hold) start1 = 1'b0;
    cycles = 0;
    while (!done1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mode = 0;
    tick(); tick();
    checks++;
    if ({a1, busy1, done1, pass1, err1, fs1, ff1} !== 17'd0) begin
      errors++;
      $display("FAIL reset_dut1: got a=%0d busy=%0b done=%0b pass=%0b err=%0d fs=%0b ff=%0d, need all 0",
               a1, busy1, done1, pass1, err1, fs1, ff1);
    end
    checks++;
    if ({a2, busy2, done2, pass2, err2, fs2, ff2} !== 17'd0) begin
      errors++;
      $display("FAIL reset_dut2: got a=%0d busy=%0b done=%0b err=%0d, need all 0", a2, busy2, done2, err2);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got busy=%0b done=%0b, need 0 0", busy1, done1);
    end
  endtask

  task automatic test_good();
    int cyc;
    mode = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || a1 !== 4'd0) begin
      errors++;
      $display("FAIL good_accept: got busy=%0b a=%0d, need 1 0", busy1, a1);
    end
    cyc = 0;
    while (!done1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 48) begin
      errors++;
      $display("FAIL good_latency: got %0d cycles, need 48", cyc);
    end
    checks++;
    if (pass1 !== 1'b1 || err1 !== 5'd0 || fs1 !== 1'b0 || busy1 !== 1'b0 || a1 !== 4'd15) begin
      errors++;
      $display("FAIL good_result: got pass=%0b err=%0d fs=%0b busy=%0b a=%0d, need 1 0 0 0 15",
               pass1, err1, fs1, busy1, a1);
    end
    tick(); tick();
    checks++;
    if (done1 !== 1'b1 || pass1 !== 1'b1 || a1 !== 4'd15) begin
      errors++;
      $display("FAIL done_hold: got done=%0b pass=%0b a=%0d, need 1 1 15", done1, pass1, a1);
    end
  endtask

  task automatic test_stuck_zero();
    int cyc;
    mode = 1;
    sweep1(1'b0, cyc);
    checks++;
    if (cyc !== 48 || err1 !== 5'd15 || ff1 !== 4'd1 || fs1 !== 1'b1 || pass1 !== 1'b0) begin
      errors++;
      $display("FAIL stuck_zero: got cyc=%0d err=%0d ff=%0d fs=%0b pass=%0b, need 48 15 1 1 0",
               cyc, err1, ff1, fs1, pass1);
    end
  endtask

  task automatic test_ones_comp();
    int cyc;
    mode = 2;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (err1 !== 5'd0 || fs1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: got err=%0d fs=%0b done=%0b, need 0 0 0", err1, fs1, done1);
    end
    cyc = 0;
    while (!done1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 48 || err1 !== 5'd16 || ff1 !== 4'd0 || fs1 !== 1'b1 || pass1 !== 1'b0) begin
      errors++;
      $display("FAIL ones_comp: got cyc=%0d err=%0d ff=%0d fs=%0b pass=%0b, need 48 16 0 1 0",
               cyc, err1, ff1, fs1, pass1);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    mode = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 0;
    while (a1 !== 4'd7 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (a1 !== 4'd7 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach7: got a=%0d busy=%0b, need 7 1", a1, busy1);
    end
    rst = 1'b1;
    start1 = 1'b1;
    tick();
    checks++;
    if ({a1, busy1, done1, pass1, err1, fs1, ff1} !== 17'd0) begin
      errors++;
      $display("FAIL mid_reset: got a=%0d busy=%0b done=%0b pass=%0b err=%0d fs=%0b ff=%0d, need all 0",
               a1, busy1, done1, pass1, err1, fs1, ff1);
    end
    rst = 1'b0;
    start1 = 1'b0;
    mode = 0;
    tick();
    sweep1(1'b0, cyc);
    checks++;
    if (cyc !== 48 || pass1 !== 1'b1 || err1 !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_sweep: got cyc=%0d pass=%0b err=%0d, need 48 1 0", cyc, pass1, err1);
    end
  endtask

  task automatic test_start_held();
    int cyc;
    mode = 1;
    sweep1(1'b1, cyc);
    checks++;
    if (cyc !== 48 || err1 !== 5'd15 || ff1 !== 4'd1 || pass1 !== 1'b0) begin
      errors++;
      $display("FAIL held_sweep: got cyc=%0d err=%0d ff=%0d pass=%0b, need 48 15 1 0", cyc, err1, ff1, pass1);
    end
    tick();
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || err1 !== 5'd0 || fs1 !== 1'b0 || a1 !== 4'd0) begin
      errors++;
      $display("FAIL held_restart: got busy=%0b done=%0b err=%0d fs=%0b a=%0d, need 1 0 0 0 0",
               busy1, done1, err1, fs1, a1);
    end
    start1 = 1'b0;
  endtask

  task automatic test_dwell1();
    logic [3:0] seen [0:31];
    int cyc;
    int n;
    int bad;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    seen[n] = a2;
    n++;
    cyc = 0;
    while (!done2 && cyc < 200) begin
      tick();
      cyc++;
      if (!done2 && n < 32) begin
        seen[n] = a2;
        n++;
      end
    end
    checks++;
    if (cyc !== 32 || pass2 !== 1'b1 || err2 !== 5'd0) begin
      errors++;
      $display("FAIL dwell1_latency: got cyc=%0d pass=%0b err=%0d, need 32 1 0", cyc, pass2, err2);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (i >= n || seen[i] !== 4'(i / 2)) bad++;
    end
    checks++;
    if (bad != 0 || n != 32) begin
      errors++;
      $display("FAIL dwell1_hold: got %0d bad samples of %0d, need 0 of 32", bad, n);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_stuck_zero();
    test_ones_comp();
    test_reset_mid();
    test_start_held();
    test_dwell1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
